iob_wishbone2iob: RTL and testbench
===================================

// Module: iob_wishbone2iob
// PURPOSE
// - Wishbone (classic, B3) subordinate to IOb manager bridge; inverse of the IOb-to-Wishbone bridge.
// - Lets a Wishbone CPU or DMA reach IOb peripherals and memories.
// - One transfer in flight; request fields are registered on entry; IOb handshake is sequenced by an FSM.
// - Exactly one ack pulse is returned per Wishbone strobe.
// PARAMETERS
// - ADDR_W     32  address width, both sides
// - DATA_W     32  data width, multiple of 8; strobe/select width = DATA_W/8
// - TIMEOUT_W  8   timeout counter width; used only when the timeout feature is compiled in
// PORTS
// - clk_i         in   1         system clock
// - cke_i         in   1         clock enable; all state holds while low
// - arst_i        in   1         asynchronous reset, active-high
// - wb_addr_i     in   ADDR_W    Wishbone address
// - wb_data_i     in   DATA_W    Wishbone write data
// - wb_select_i   in   DATA_W/8  Wishbone byte select
// - wb_we_i       in   1         Wishbone write enable
// - wb_cyc_i      in   1         Wishbone cycle
// - wb_stb_i      in   1         Wishbone strobe
// - wb_ack_o      out  1         Wishbone acknowledge, one-cycle pulse
// - wb_data_o     out  DATA_W    Wishbone read data
// - iob_valid_o   out  1         IOb request valid
// - iob_addr_o    out  ADDR_W    IOb address
// - iob_wdata_o   out  DATA_W    IOb write data
// - iob_wstrb_o   out  DATA_W/8  IOb write strobe; all zeros means read
// - iob_ready_i   in   1         IOb request accepted
// - iob_rvalid_i  in   1         IOb read data valid
// - iob_rdata_i   in   DATA_W    IOb read data
// BEHAVIOUR
// - Reset: all outputs 0, FSM in IDLE, read-data register 0.
// - All outputs are registered; nothing combinational from inputs to outputs.
// - FSM states: IDLE, REQ, RDWAIT, ACK.
// - IDLE:
//   - On wb_cyc_i & wb_stb_i, latch the request:
//     - iob_addr_o  <= wb_addr_i
//     - iob_wdata_o <= wb_data_i
//     - iob_wstrb_o <= wb_we_i ? wb_select_i : 0
//   - Set iob_valid_o; go to REQ.
// - REQ:
//   - iob_valid_o and all request fields are held stable until iob_ready_i.
//   - On iob_ready_i: drop iob_valid_o next cycle; write -> ACK; read -> RDWAIT.
// - RDWAIT: on iob_rvalid_i, wb_data_o <= iob_rdata_i; go to ACK.
//   - iob_rvalid_i in any other state is ignored.
// - ACK:
//   - wb_ack_o is high for exactly this one cycle, then IDLE.
//   - wb_data_o holds the last read value until the next read completes.
// - Minimum latency, stb sampled in cycle T:
//   - iob_valid_o at T+1.
//   - Write with ready at T+1: ack at T+2.
//   - Read with ready at T+1 and rvalid at T+2: ack at T+3.
// - Back-to-back: a stb still high in the IDLE cycle after ACK starts a new transfer; no stb is ever acked twice.
// - Abort (wb_cyc_i low while in REQ/RDWAIT):
//   - The IOb transaction still completes; IOb valid is never withdrawn before ready.
//   - ACK is skipped and the FSM returns to IDLE; read data is discarded.
// - wb_stb_i without wb_cyc_i is ignored.
// - iob_ready_i is not registered back to Wishbone; it only advances the FSM.
// - arst_i mid-transfer forces IDLE and zeroes outputs immediately.
// CONFIGURATION
// - IOB_WISHBONE2IOB_TIMEOUT_EN defined:
//   - Adds port wb_err_o (out, 1) and a TIMEOUT_W-bit counter.
//   - Counter clears on entry to REQ and increments each cycle in REQ/RDWAIT.
//   - At count 2**TIMEOUT_W-1: iob_valid_o drops, FSM goes to ACK, and wb_err_o pulses instead of wb_ack_o.
//   - A late rvalid is ignored.
// - Macro undefined: no wb_err_o port, no counter; the FSM waits indefinitely.
// TESTING
// - Write addr 0x10, data 0xDEADBEEF, sel 0xF, ready tied 1 -> iob_wstrb_o=0xF for one cycle; wb_ack_o at T+2.
// - Read addr 0x20, ready after 3 cycles, rvalid 2 cycles later with 0x12345678
//   -> iob_valid_o held 4 cycles, iob_wstrb_o=0, wb_data_o=0x12345678 with the single ack.
// - Byte write sel 0x4, data 0x00AB0000 -> iob_wstrb_o=0x4, iob_wdata_o=0x00AB0000.
// - Back-to-back writes W1 then W2 (stb held high) -> exactly two valid/ack pairs, in order.
// - cyc dropped during RDWAIT -> no wb_ack_o, FSM back to IDLE, next read behaves normally.
// - TIMEOUT_EN, TIMEOUT_W=4, ready never asserted -> wb_err_o pulses 16 cycles after stb, no ack.
//   - Also: arst_i mid-REQ -> all outputs 0 at once.

Source files
------------

// File: rtl/iob_wishbone2iob.sv
// Wishbone B3 classic subordinate to IOb manager bridge: one registered transfer in flight.
// Optional IOb-side timeout with wb_err_o is compiled in by IOB_WISHBONE2IOB_TIMEOUT_EN.
module iob_wishbone2iob #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef IOB_WISHBONE2IOB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_W = 8
`endif
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                arst_i,
  input  logic [ADDR_W-1:0]   wb_addr_i,
  input  logic [DATA_W-1:0]   wb_data_i,
  input  logic [DATA_W/8-1:0] wb_select_i,
  input  logic                wb_we_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  output logic                wb_ack_o,
  output logic [DATA_W-1:0]   wb_data_o,
`ifdef IOB_WISHBONE2IOB_TIMEOUT_EN
  output logic                wb_err_o,
`endif
  output logic                iob_valid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic                iob_ready_i,
  input  logic                iob_rvalid_i,
  input  logic [DATA_W-1:0]   iob_rdata_i
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    RDWAIT = 2'd2,
    ACK    = 2'd3
  } state_t;

  state_t state_r;
  logic   we_r;
  logic   abort_r;
  logic   abort_s;
  logic   tmo_s;

  // Once the manager drops cyc the IOb side still finishes, but the answer is thrown away.
  assign abort_s = abort_r | ~wb_cyc_i;

`ifdef IOB_WISHBONE2IOB_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TMO_LAST =
    {TIMEOUT_W{1'b1}} - {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  logic [TIMEOUT_W-1:0] tmo_cnt_r;

  // Cycles spent waiting on the IOb side; zero while idle so it starts at 0 in REQ
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      tmo_cnt_r <= {TIMEOUT_W{1'b0}};
    end else if (cke_i) begin
      if (state_r == IDLE) begin
        tmo_cnt_r <= {TIMEOUT_W{1'b0}};
      end else if ((state_r == REQ) || (state_r == RDWAIT)) begin
        tmo_cnt_r <= tmo_cnt_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
      end else begin
        tmo_cnt_r <= tmo_cnt_r;
      end
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  // Fires one cycle early so the error pulse lines up with the counter reaching all-ones
  assign tmo_s = ((state_r == REQ) || (state_r == RDWAIT)) && (tmo_cnt_r == TMO_LAST);
`else
  assign tmo_s = 1'b0;
`endif

  // Request capture, IOb handshake sequencing and registered Wishbone responses
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_r     <= IDLE;
      we_r        <= 1'b0;
      abort_r     <= 1'b0;
      iob_valid_o <= 1'b0;
      iob_addr_o  <= {ADDR_W{1'b0}};
      iob_wdata_o <= {DATA_W{1'b0}};
      iob_wstrb_o <= {STRB_W{1'b0}};
      wb_ack_o    <= 1'b0;
      wb_data_o   <= {DATA_W{1'b0}};
`ifdef IOB_WISHBONE2IOB_TIMEOUT_EN
      wb_err_o    <= 1'b0;
`endif
    end else if (cke_i) begin
      case (state_r)
        IDLE: begin
          wb_ack_o <= 1'b0;
`ifdef IOB_WISHBONE2IOB_TIMEOUT_EN
          wb_err_o <= 1'b0;
`endif
          abort_r  <= 1'b0;
          if (wb_cyc_i && wb_stb_i) begin
            iob_addr_o  <= wb_addr_i;
            iob_wdata_o <= wb_data_i;
            iob_wstrb_o <= wb_we_i ? wb_select_i : {STRB_W{1'b0}};
            we_r        <= wb_we_i;
            iob_valid_o <= 1'b1;
            state_r     <= REQ;
          end else begin
            iob_valid_o <= 1'b0;
            state_r     <= IDLE;
          end
        end
        REQ: begin
          abort_r <= abort_s;
          if (iob_ready_i) begin
            iob_valid_o <= 1'b0;
            if (we_r) begin
              wb_ack_o <= ~abort_s;
              state_r  <= abort_s ? IDLE : ACK;
            end else begin
              state_r  <= RDWAIT;
            end
          end else if (tmo_s) begin
            iob_valid_o <= 1'b0;
`ifdef IOB_WISHBONE2IOB_TIMEOUT_EN
            wb_err_o    <= ~abort_s;
`endif
            state_r     <= abort_s ? IDLE : ACK;
          end else begin
            state_r <= REQ;
          end
        end
        RDWAIT: begin
          abort_r <= abort_s;
          if (iob_rvalid_i) begin
            if (abort_s) begin
              state_r <= IDLE;
            end else begin
              wb_data_o <= iob_rdata_i;
              wb_ack_o  <= 1'b1;
              state_r   <= ACK;
            end
          end else if (tmo_s) begin
`ifdef IOB_WISHBONE2IOB_TIMEOUT_EN
            wb_err_o <= ~abort_s;
`endif
            state_r  <= abort_s ? IDLE : ACK;
          end else begin
            state_r <= RDWAIT;
          end
        end
        ACK: begin
          wb_ack_o <= 1'b0;
`ifdef IOB_WISHBONE2IOB_TIMEOUT_EN
          wb_err_o <= 1'b0;
`endif
          state_r  <= IDLE;
        end
        default: begin
          iob_valid_o <= 1'b0;
          wb_ack_o    <= 1'b0;
`ifdef IOB_WISHBONE2IOB_TIMEOUT_EN
          wb_err_o    <= 1'b0;
`endif
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iob_wishbone2iob.sv
// Directed bench for iob_wishbone2iob: vector table for single transfers plus hand-written corner sequences.
module tb_iob_wishbone2iob;

  logic        clk = 1'b0;
  logic        cke;
  logic        arst;
  logic [31:0] wb_addr;
  logic [31:0] wb_wdata;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_ack;
  logic [31:0] wb_rdata;
  logic        iob_valid;
  logic [31:0] iob_addr;
  logic [31:0] iob_wdata;
  logic [3:0]  iob_wstrb;
  logic        iob_ready;
  logic        iob_rvalid;
  logic [31:0] iob_rdata;
`ifdef IOB_WISHBONE2IOB_TIMEOUT_EN
  logic        wb_err;
`endif

  int total = 0;
  int bad   = 0;

  iob_wishbone2iob #(
    .ADDR_W(32),
    .DATA_W(32)
`ifdef IOB_WISHBONE2IOB_TIMEOUT_EN
    ,
    .TIMEOUT_W(4)
`endif
  ) dut (
    .clk_i       (clk),
    .cke_i       (cke),
    .arst_i      (arst),
    .wb_addr_i   (wb_addr),
    .wb_data_i   (wb_wdata),
    .wb_select_i (wb_sel),
    .wb_we_i     (wb_we),
    .wb_cyc_i    (wb_cyc),
    .wb_stb_i    (wb_stb),
    .wb_ack_o    (wb_ack),
    .wb_data_o   (wb_rdata),
`ifdef IOB_WISHBONE2IOB_TIMEOUT_EN
    .wb_err_o    (wb_err),
`endif
    .iob_valid_o (iob_valid),
    .iob_addr_o  (iob_addr),
    .iob_wdata_o (iob_wdata),
    .iob_wstrb_o (iob_wstrb),
    .iob_ready_i (iob_ready),
    .iob_rvalid_i(iob_rvalid),
    .iob_rdata_i (iob_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    int          rdy_dly;
    int          rv_dly;
    logic [31:0] rdata;
    logic [3:0]  exp_wstrb;
    int          exp_valid;
    int          exp_ack;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issues one strobe at cycle 0 and plays the IOb peer for 12 cycles.
  task automatic run_vec(input int idx, input vec_t v);
    int valid_cnt = 0;
    int ack_cnt = 0;
    int ack_at = -1;
    int field_bad = 0;
    int rdy_cyc;
    int rv_cyc;
    logic [3:0]  wstrb_seen = 4'hA;
    logic [31:0] data_at_ack = 32'hFFFF_FFFF;
    rdy_cyc  = 1 + v.rdy_dly;
    rv_cyc   = rdy_cyc + v.rv_dly;
    wb_addr  = v.addr;
    wb_wdata = v.data;
    wb_sel   = v.sel;
    wb_we    = v.we;
    wb_cyc   = 1'b1;
    wb_stb   = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (iob_valid) begin
        if (valid_cnt == 0) wstrb_seen = iob_wstrb;
        valid_cnt++;
        if (iob_addr !== v.addr || iob_wdata !== v.data || iob_wstrb !== v.exp_wstrb) field_bad++;
      end
      if (wb_ack) begin
        ack_cnt++;
        ack_at = k;
        data_at_ack = wb_rdata;
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
      end
      iob_ready  = (k == rdy_cyc);
      iob_rvalid = (!v.we && k == rv_cyc);
      iob_rdata  = iob_rvalid ? v.rdata : 32'hFFFF_FFFF;
    end
    iob_ready  = 1'b0;
    iob_rvalid = 1'b0;
    check($sformatf("v%0d_valid_cycles", idx), 64'(valid_cnt), 64'(v.exp_valid));
    check($sformatf("v%0d_wstrb", idx), 64'(wstrb_seen), 64'(v.exp_wstrb));
    check($sformatf("v%0d_fields_stable", idx), 64'(field_bad), 64'd0);
    check($sformatf("v%0d_ack_count", idx), 64'(ack_cnt), 64'd1);
    check($sformatf("v%0d_ack_cycle", idx), 64'(ack_at), 64'(v.exp_ack));
    check($sformatf("v%0d_rdata_at_ack", idx), 64'(data_at_ack), 64'(v.exp_rd));
  endtask

  initial begin
    int nv;
    int na;
    logic [31:0] va[2];
    int aat[2];

    // we, addr, data, sel, rdy_dly, rv_dly, rdata, exp_wstrb, exp_valid, exp_ack, exp_rd
    vecs[0] = '{1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'h0,         4'hF, 1, 2, 32'h0};
    vecs[1] = '{1'b0, 32'h20, 32'h0,         4'hF, 3, 2, 32'h1234_5678, 4'h0, 4, 7, 32'h1234_5678};
    vecs[2] = '{1'b1, 32'h24, 32'h00AB_0000, 4'h4, 1, 0, 32'h0,         4'h4, 2, 3, 32'h1234_5678};
    vecs[3] = '{1'b0, 32'h30, 32'h7,         4'h3, 0, 1, 32'hCAFE_F00D, 4'h0, 1, 3, 32'hCAFE_F00D};
    vecs[4] = '{1'b0, 32'h40, 32'h0,         4'hF, 0, 1, 32'h0F0F_0F0F, 4'h0, 1, 3, 32'h0F0F_0F0F};

    cke = 1'b1; arst = 1'b1;
    wb_addr = 32'h0; wb_wdata = 32'h0; wb_sel = 4'h0; wb_we = 1'b0;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    iob_ready = 1'b0; iob_rvalid = 1'b0; iob_rdata = 32'h0;
    tick(); tick();
    check("rst_valid", 64'(iob_valid), 64'd0);
    check("rst_ack", 64'(wb_ack), 64'd0);
    check("rst_addr", 64'(iob_addr), 64'd0);
    check("rst_wdata", 64'(iob_wdata), 64'd0);
    check("rst_wstrb", 64'(iob_wstrb), 64'd0);
    check("rst_rdata", 64'(wb_rdata), 64'd0);
    arst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) run_vec(i, vecs[i]);

    // Back-to-back writes with stb held high and ready tied high
    nv = 0; na = 0; va[0] = 32'h0; va[1] = 32'h0; aat[0] = -1; aat[1] = -1;
    wb_we = 1'b1; wb_sel = 4'hF; wb_addr = 32'h100; wb_wdata = 32'h1111_1111;
    wb_cyc = 1'b1; wb_stb = 1'b1; iob_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (iob_valid) begin
        if (nv < 2) va[nv] = iob_addr;
        nv++;
      end
      if (wb_ack) begin
        if (na < 2) aat[na] = k;
        na++;
        if (na == 1) begin
          wb_addr = 32'h104; wb_wdata = 32'h2222_2222;
        end else begin
          wb_cyc = 1'b0; wb_stb = 1'b0;
        end
      end
    end
    iob_ready = 1'b0;
    check("b2b_valid_count", 64'(nv), 64'd2);
    check("b2b_ack_count", 64'(na), 64'd2);
    check("b2b_addr0", 64'(va[0]), 64'h100);
    check("b2b_addr1", 64'(va[1]), 64'h104);
    check("b2b_ack0_cycle", 64'(aat[0]), 64'd2);
    check("b2b_ack1_cycle", 64'(aat[1]), 64'd5);

    // stb without cyc must not start anything
    nv = 0;
    wb_cyc = 1'b0; wb_stb = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (iob_valid || wb_ack) nv++;
    end
    wb_stb = 1'b0;
    check("stb_no_cyc_ignored", 64'(nv), 64'd0);

    // Clock enable low freezes the FSM even with a strobe pending
    nv = 0; na = 0;
    cke = 1'b0; wb_we = 1'b1; wb_addr = 32'h200; wb_wdata = 32'h3333_3333;
    wb_cyc = 1'b1; wb_stb = 1'b1; iob_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (iob_valid) nv++;
    end
    check("cke_low_holds", 64'(nv), 64'd0);
    cke = 1'b1;
    tick();
    check("cke_high_valid", 64'(iob_valid), 64'd1);
    tick();
    check("cke_high_ack", 64'(wb_ack), 64'd1);
    wb_cyc = 1'b0; wb_stb = 1'b0; iob_ready = 1'b0;
    tick();

    // Abort: cyc dropped while waiting for read data
    na = 0;
    wb_we = 1'b0; wb_addr = 32'h300; wb_cyc = 1'b1; wb_stb = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (wb_ack) na++;
      iob_ready = (k == 1);
      if (k == 2) begin
        wb_cyc = 1'b0; wb_stb = 1'b0;
      end
      iob_rvalid = (k == 3);
      iob_rdata  = (k == 3) ? 32'hBADB_AD00 : 32'h0;
    end
    iob_ready = 1'b0; iob_rvalid = 1'b0;
    check("abort_no_ack", 64'(na), 64'd0);
    check("abort_rdata_discarded", 64'(wb_rdata), 64'hCAFE_F00D);
    run_vec(4, vecs[4]);

`ifdef IOB_WISHBONE2IOB_TIMEOUT_EN
    // Timeout: ready never comes
    begin
      int ne = 0;
      int err_at = -1;
      na = 0;
      wb_we = 1'b0; wb_addr = 32'h500; wb_cyc = 1'b1; wb_stb = 1'b1;
      for (int k = 1; k <= 20; k++) begin
        tick();
        if (wb_ack) na++;
        if (wb_err) begin
          ne++; err_at = k; wb_cyc = 1'b0; wb_stb = 1'b0;
        end
      end
      check("tmo_err_count", 64'(ne), 64'd1);
      check("tmo_err_cycle", 64'(err_at), 64'd16);
      check("tmo_no_ack", 64'(na), 64'd0);
    end
`endif

    // Asynchronous reset in the middle of a request
    wb_we = 1'b0; wb_addr = 32'h400; wb_wdata = 32'h55; wb_cyc = 1'b1; wb_stb = 1'b1;
    tick(); tick();
    check("arst_pre_valid", 64'(iob_valid), 64'd1);
    #2 arst = 1'b1;
    #1;
    check("arst_valid", 64'(iob_valid), 64'd0);
    check("arst_addr", 64'(iob_addr), 64'd0);
    check("arst_wdata", 64'(iob_wdata), 64'd0);
    check("arst_rdata", 64'(wb_rdata), 64'd0);
    check("arst_ack", 64'(wb_ack), 64'd0);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    tick();
    arst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
